uart_boot_loader_ctrl: RTL and testbench



---
 rtl/loader_pkg.sv | 40 ++++
 rtl/loader_timeout_timer.sv | 37 +++
 rtl/uart_boot_loader_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_boot_loader_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared state encoding, default framing bytes and state helpers
//          for the UART boot loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_SEND   = 3'd5,
        ST_RUN    = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] c_ACK_BYTE  = 8'h06;
    localparam logic [7:0] c_NAK_BYTE  = 8'h15;

    // States in which a frame is considered in progress.
    function automatic logic in_frame(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) ||
               (s == ST_CSUM)   || (s == ST_SEND);
    endfunction

    // States in which the inter-byte timeout is armed.
    function automatic logic is_timed(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) ||
               (s == ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_timeout_timer.sv
// ============================================================================
// Module : loader_timeout_timer
// Brief  : Inter-byte watchdog; o_terminal is high while the count sits at
//          TIMEOUT_CYC-1 and the timer is enabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_timeout_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int                c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count != c_TERM) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Not masked by i_clear: a timeout outranks a byte arriving the same cycle.
    assign o_terminal = i_enable && (r_count == c_TERM);

endmodule

`default_nettype wire

// File: rtl/uart_boot_loader_ctrl.sv
// ============================================================================
// Module : uart_boot_loader_ctrl
// Brief  : Receives a framed program over UART, writes it to imem, checks an
//          XOR checksum, answers ACK/NAK and releases the CPU from reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_boot_loader_ctrl
    import loader_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] SYNC_BYTE   = c_SYNC_BYTE,
    parameter logic [7:0] ACK_BYTE    = c_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE    = c_NAK_BYTE,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              reload_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              loader_busy,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] c_MAX_LEN = 17'(2 ** ADDR_W);

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_len, w_len_nxt;
    logic [1:0]          r_byte_idx, w_byte_idx_nxt;
    logic [23:0]         r_shift, w_shift_nxt;
    logic [7:0]          r_csum, w_csum_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_tx_start, w_tx_start_nxt;
    logic [7:0]          r_tx_data, w_tx_data_nxt;
    logic                r_imem_we, w_imem_we_nxt;
    logic [ADDR_W-1:0]   r_imem_addr, w_imem_addr_nxt;
    logic [31:0]         r_imem_wdata, w_imem_wdata_nxt;
    logic                r_cpu_reset, w_cpu_reset_nxt;
    logic                r_busy;
    logic                r_load_error, w_load_error_nxt;
    logic [15:0]         r_words, w_words_nxt;
    logic                w_timer_en;
    logic                w_timeout;
    logic                w_sync;
    logic [15:0]         w_len_full;

    assign w_timer_en = is_timed(r_state);
    assign w_sync     = rx_valid && (rx_data == SYNC_BYTE);
    assign w_len_full = {rx_data, r_len[7:0]};

    loader_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (rx_valid),
        .i_enable   (w_timer_en),
        .o_terminal (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_csum       <= '0;
            r_ack        <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_load_error <= 1'b0;
            r_words      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_csum       <= w_csum_nxt;
            r_ack        <= w_ack_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_wdata <= w_imem_wdata_nxt;
            r_cpu_reset  <= w_cpu_reset_nxt;
            r_busy       <= in_frame(w_state_nxt);
            r_load_error <= w_load_error_nxt;
            r_words      <= w_words_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_len_nxt        = r_len;
        w_byte_idx_nxt   = r_byte_idx;
        w_shift_nxt      = r_shift;
        w_csum_nxt       = r_csum;
        w_ack_nxt        = r_ack;
        w_tx_start_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_imem_we_nxt    = 1'b0;
        // The address steps the cycle after each write, so it names the word just written during the strobe.
        w_imem_addr_nxt  = r_imem_addr + {{(ADDR_W-1){1'b0}}, r_imem_we};
        w_imem_wdata_nxt = r_imem_wdata;
        w_cpu_reset_nxt  = r_cpu_reset;
        w_load_error_nxt = r_load_error;
        w_words_nxt      = r_words;

        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if ((r_state == ST_ERROR) && reload_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sync) begin
                    w_state_nxt      = ST_LEN_LO;
                    w_words_nxt      = '0;
                    w_csum_nxt       = '0;
                    w_load_error_nxt = 1'b0;
                    w_imem_addr_nxt  = '0;
                end
            end
            ST_LEN_LO: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEND;
                    w_ack_nxt   = 1'b0;
                end else if (rx_valid) begin
                    w_len_nxt   = {8'h00, rx_data};
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEND;
                    w_ack_nxt   = 1'b0;
                end else if (rx_valid) begin
                    w_len_nxt      = w_len_full;
                    w_byte_idx_nxt = '0;
                    if ((w_len_full == 16'd0) || ({1'b0, w_len_full} > c_MAX_LEN)) begin
                        w_state_nxt = ST_SEND;
                        w_ack_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEND;
                    w_ack_nxt   = 1'b0;
                end else if (rx_valid) begin
                    w_csum_nxt     = r_csum ^ rx_data;
                    w_shift_nxt    = {rx_data, r_shift[23:8]};
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        w_imem_we_nxt    = 1'b1;
                        w_imem_wdata_nxt = {rx_data, r_shift};
                        w_words_nxt      = r_words + 16'd1;
                        if ((r_words + 16'd1) == r_len) begin
                            w_state_nxt = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEND;
                    w_ack_nxt   = 1'b0;
                end else if (rx_valid) begin
                    w_state_nxt = ST_SEND;
                    w_ack_nxt   = (rx_data == r_csum);
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    w_tx_start_nxt   = 1'b1;
                    w_tx_data_nxt    = r_ack ? ACK_BYTE : NAK_BYTE;
                    w_state_nxt      = r_ack ? ST_RUN : ST_ERROR;
                    w_cpu_reset_nxt  = !r_ack;
                    w_load_error_nxt = !r_ack;
                end
            end
            ST_RUN: begin
                if (reload_req) begin
                    w_state_nxt     = ST_IDLE;
                    w_cpu_reset_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx_start     = r_tx_start;
    assign tx_data      = r_tx_data;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign loader_busy  = r_busy;
    assign load_error   = r_load_error;
    assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader_ctrl.sv
// ============================================================================
// Module : tb_uart_boot_loader_ctrl
// Brief  : Directed frames against a frame-level expectation model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_boot_loader_ctrl;

    localparam int         ADDR_W = 10;
    localparam int         TMO    = 50;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              tx_busy = 1'b0;
    logic              reload_req = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              loader_busy;
    logic              load_error;
    logic [15:0]       words_loaded;

    uart_boot_loader_ctrl #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .reload_req   (reload_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .loader_busy  (loader_busy),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct { int c; logic [ADDR_W-1:0] a; logic [31:0] d; logic [15:0] n; } wr_t;
    typedef struct { int c; logic [7:0] b; } tx_t;

    wr_t        wq[$];
    tx_t        tq[$];
    wr_t        wr_got;
    tx_t        tx_got;
    logic [7:0] frame[$];
    logic [31:0] shadow [0:3];
    logic [7:0] last_tx = 8'h00;
    int         tx_cyc = 0;
    int         tx_count = 0;
    int         last_e = 0;
    logic              prev_we = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ADDR_W-1:0] next_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name, input int got_cyc, input int req_cyc);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event at cycle %0d, required cycle %0d", name, got_cyc, req_cyc);
    endtask

    // Compare process: every strobe must match a queued expectation at its exact cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we) begin
                if (addr_ok(imem_addr)) shadow[imem_addr[1:0]] = imem_wdata;
                if (wq.size() == 0) begin
                    bad("imem_we_unexpected", cyc, -1);
                end else begin
                    wr_got = wq.pop_front();
                    chk("imem_we_cycle", cyc, wr_got.c);
                    chk("imem_addr", 32'(imem_addr), 32'(wr_got.a));
                    chk("imem_wdata", imem_wdata, wr_got.d);
                    chk("words_at_write", 32'(words_loaded), 32'(wr_got.n));
                end
            end else if (wq.size() > 0 && wq[0].c <= cyc) begin
                bad("imem_we_missing", cyc, wq[0].c);
                void'(wq.pop_front());
            end
            if (prev_we) begin
                next_addr = prev_addr + 1'b1;
                chk("imem_addr_advance", 32'(imem_addr), 32'(next_addr));
            end
            prev_we   = imem_we;
            prev_addr = imem_addr;

            if (tx_start) begin
                last_tx = tx_data;
                tx_cyc  = cyc;
                tx_count++;
                if (tq.size() == 0) begin
                    bad("tx_start_unexpected", cyc, -1);
                end else begin
                    tx_got = tq.pop_front();
                    chk("tx_cycle", cyc, tx_got.c);
                    chk("tx_data", 32'(tx_data), 32'(tx_got.b));
                    chk("tx_cpu_reset", 32'(cpu_reset), (tx_got.b == NAK) ? 32'd1 : 32'd0);
                    chk("tx_load_error", 32'(load_error), (tx_got.b == NAK) ? 32'd1 : 32'd0);
                    chk("tx_not_busy", 32'(loader_busy), 32'd0);
                end
            end else if (tq.size() > 0 && tq[0].c <= cyc) begin
                bad("tx_start_missing", cyc, tq[0].c);
                void'(tq.pop_front());
            end
            if (loader_busy) chk("busy_holds_cpu", 32'(cpu_reset), 32'd1);
        end
    end

    function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
        return a < 4;
    endfunction

    task automatic send_byte(input logic [7:0] b, output int e);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        e        = cyc + 1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Frame-level model: derives writes and the reply from the frame bytes alone.
    task automatic send_frame(input bit hold_tx);
        int         len, e;
        logic [7:0] x;
        wr_t        w;
        tx_t        t;
        len = int'({frame[2], frame[1]});
        x   = 8'h00;
        e   = 0;
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], e);
            if (i == 2 && (len == 0 || len > (1 << ADDR_W))) begin
                t.c = e + 1; t.b = NAK;
                if (!hold_tx) tq.push_back(t);
            end else if (i >= 3 && i < 3 + 4 * len) begin
                x ^= frame[i];
                if ((i - 3) % 4 == 3) begin
                    w.c = e;
                    w.a = ADDR_W'((i - 3) / 4);
                    w.d = {frame[i], frame[i-1], frame[i-2], frame[i-3]};
                    w.n = 16'((i - 3) / 4 + 1);
                    wq.push_back(w);
                end
            end else if (i == 3 + 4 * len && i > 2) begin
                t.c = e + 1; t.b = (frame[i] == x) ? ACK : NAK;
                if (!hold_tx) tq.push_back(t);
            end
        end
        last_e = e;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload_req = 1'b1;
        @(negedge clk);
        reload_req = 1'b0;
    endtask

    initial begin
        int  e;
        tx_t t;
        int  cnt0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_busy", 32'(loader_busy), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Good two-word frame
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_frame(1'b0);
        repeat (4) @(negedge clk);
        chk("good_imem0", shadow[0], 32'h0000_0013);
        chk("good_imem1", shadow[1], 32'h0010_0093);
        chk("good_tx_ack", 32'(last_tx), 32'h06);
        chk("good_words", 32'(words_loaded), 32'd2);
        chk("good_cpu_run", 32'(cpu_reset), 32'd0);

        pulse_reload();
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_idle", 32'(loader_busy), 32'd0);

        // Same frame, wrong checksum
        frame[11] = 8'h91;
        send_frame(1'b0);
        repeat (4) @(negedge clk);
        chk("badcs_tx_nak", 32'(last_tx), 32'h15);
        chk("badcs_error", 32'(load_error), 32'd1);
        chk("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("badcs_words", 32'(words_loaded), 32'd2);

        // LEN = 0 from ERROR; SYNC clears the sticky error
        send_byte(8'hA5, e);
        chk("sync_clears_error", 32'(load_error), 32'd0);
        chk("sync_busy", 32'(loader_busy), 32'd1);
        chk("sync_clears_words", 32'(words_loaded), 32'd0);
        send_byte(8'h00, e);
        send_byte(8'h00, e);
        t.c = e + 1; t.b = NAK;
        tq.push_back(t);
        repeat (4) @(negedge clk);
        chk("len0_tx_nak", 32'(last_tx), 32'h15);
        chk("len0_error", 32'(load_error), 32'd1);

        // LEN = 0x401 exceeds 2**ADDR_W
        frame = '{8'hA5, 8'h01, 8'h04};
        send_frame(1'b0);
        repeat (4) @(negedge clk);
        chk("lenbig_tx_nak", 32'(last_tx), 32'h15);
        chk("lenbig_cpu_reset", 32'(cpu_reset), 32'd1);

        // Timeout after two data bytes
        pulse_reload();
        chk("err_reload_idle", 32'(loader_busy), 32'd0);
        frame = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send_frame(1'b0);
        t.c = last_e + TMO + 1; t.b = NAK;
        tq.push_back(t);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_tx_nak", 32'(last_tx), 32'h15);
        chk("tmo_latency", 32'(tx_cyc - last_e), 32'd51);
        chk("tmo_no_words", 32'(words_loaded), 32'd0);

        // Clean restart with a one-word frame
        frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_frame(1'b0);
        repeat (4) @(negedge clk);
        chk("restart_imem0", shadow[0], 32'h1234_5678);
        chk("restart_words", 32'(words_loaded), 32'd1);
        chk("restart_tx_ack", 32'(last_tx), 32'h06);
        chk("restart_cpu_run", 32'(cpu_reset), 32'd0);

        // tx_busy held for 20 cycles at SEND
        pulse_reload();
        tx_busy = 1'b1;
        send_frame(1'b1);
        cnt0 = tx_count;
        repeat (20) @(negedge clk);
        chk("txbusy_waiting", 32'(loader_busy), 32'd1);
        chk("txbusy_no_start", 32'(tx_count - cnt0), 32'd0);
        tx_busy = 1'b0;
        t.c = cyc + 1; t.b = ACK;
        tq.push_back(t);
        repeat (5) @(negedge clk);
        chk("txbusy_one_start", 32'(tx_count - cnt0), 32'd1);
        chk("txbusy_cpu_run", 32'(cpu_reset), 32'd0);

        // Reset in the middle of DATA
        pulse_reload();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_frame(1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(loader_busy), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        chk("midrst_addr", 32'(imem_addr), 32'd0);
        frame = '{8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        foreach (frame[i]) send_byte(frame[i], e);
        repeat (5) @(negedge clk);
        chk("midrst_idle_words", 32'(words_loaded), 32'd0);
        chk("midrst_idle_busy", 32'(loader_busy), 32'd0);
        chk("pending_writes", 32'(wq.size()), 32'd0);
        chk("pending_tx", 32'(tq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
